// File: rtl/dro_pulse_sequencer.sv
// Command sequencer for a destructive-readout (DRO) cell: issues set/reset pulses and samples the DRO output.
// Optional macro DRO_SEQ_STRAY_CNT_EN enables the saturating stray-pulse counter on stray_cnt.
module dro_pulse_sequencer #(
    parameter int SEP_CYCLES = 3,
    parameter int WINDOW     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_op,
    output logic       cmd_ready,
    output logic       dro_set,
    output logic       dro_reset,
    input  logic       dro_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_data,
    output logic       rsp_err,
    output logic       stray_err,
    output logic [7:0] stray_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SET_PULSE,
        GUARD,
        RST_PULSE,
        WAIT_OUT,
        RESP
    } state_t;

    localparam logic [3:0] SEP_LAST = 4'(SEP_CYCLES - 1);
    localparam logic [3:0] WIN_LAST = 4'(WINDOW - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       run_q;
    logic       exp_q, exp_d;
    logic       cap_q, cap_d;
    logic       err_q, err_d;
    logic       stray_err_q, stray_err_d;
    logic       cap_now;
    logic       stray_hit;

    assign cap_now   = cap_q | dro_out;
    assign stray_hit = dro_out && (state_q != WAIT_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            exp_q       <= 1'b0;
            cap_q       <= 1'b0;
            err_q       <= 1'b0;
            stray_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= 1'b1;
            exp_q       <= exp_d;
            cap_q       <= cap_d;
            err_q       <= err_d;
            stray_err_q <= stray_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        cap_d       = cap_q;
        err_d       = err_q;
        stray_err_d = stray_err_q | stray_hit;
        cmd_ready   = 1'b0;
        dro_set     = 1'b0;
        dro_reset   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = 1'b0;
        rsp_err     = 1'b0;

        case (state_q)
            IDLE: begin
                // run_q holds cmd_ready low until the first edge after reset release
                cmd_ready = run_q;
                if (run_q && cmd_valid) begin
                    if (cmd_op) begin
                        state_d = RST_PULSE;
                        cap_d   = 1'b0;
                    end else begin
                        state_d = SET_PULSE;
                        exp_d   = 1'b1;
                    end
                end
            end
            SET_PULSE: begin
                dro_set = 1'b1;
                state_d = GUARD;
                cnt_d   = SEP_LAST;
            end
            GUARD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RST_PULSE: begin
                dro_reset = 1'b1;
                state_d   = WAIT_OUT;
                cnt_d     = WIN_LAST;
            end
            WAIT_OUT: begin
                cap_d = cap_now;
                if (cnt_q == 4'd0) begin
                    // error is latched here because the expected bit is destroyed on entry to RESP
                    state_d = RESP;
                    err_d   = cap_now ^ exp_q;
                    exp_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = cap_q;
                rsp_err   = err_q;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stray_err = stray_err_q;

`ifdef DRO_SEQ_STRAY_CNT_EN
    logic [7:0] stray_cnt_q, stray_cnt_d;

    always_comb begin
        stray_cnt_d = stray_cnt_q;
        if (stray_hit && (stray_cnt_q != 8'hFF)) begin
            stray_cnt_d = stray_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_cnt_q <= '0;
        end else begin
            stray_cnt_q <= stray_cnt_d;
        end
    end

    assign stray_cnt = stray_cnt_q;
`else
    assign stray_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dro_pulse_sequencer.sv
// Self-checking bench for dro_pulse_sequencer (SEP_CYCLES=3, WINDOW=4) with an in-bench DRO cell model.
module tb_dro_pulse_sequencer;

    localparam int SEP = 3;
    localparam int WIN = 4;

`ifdef DRO_SEQ_STRAY_CNT_EN
    localparam logic [7:0] CNT3 = 8'd3;
`else
    localparam logic [7:0] CNT3 = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_op = 1'b0;
    logic       dro_out = 1'b0;
    logic       rsp_ready = 1'b0;
    logic       cmd_ready;
    logic       dro_set;
    logic       dro_reset;
    logic       rsp_valid;
    logic       rsp_data;
    logic       rsp_err;
    logic       stray_err;
    logic [7:0] stray_cnt;

    int total = 0;
    int bad   = 0;

    bit model_stored = 1'b0;
    bit exp_model    = 1'b0;
    logic [1:0] sb_q[$];

    always #5 clk = ~clk;

    dro_pulse_sequencer #(
        .SEP_CYCLES(SEP),
        .WINDOW(WIN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_ready(cmd_ready),
        .dro_set(dro_set),
        .dro_reset(dro_reset),
        .dro_out(dro_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .stray_err(stray_err),
        .stray_cnt(stray_cnt)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge of cycle T+1 after acceptance edge T.
    task automatic issue(input bit op);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready got=%b required=1", cmd_ready);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom_range(0, 1));
    endtask

    task automatic prep_read(input bit suppress, output bit cap);
        cap = model_stored && !suppress;
        sb_q.push_back({cap, cap ^ exp_model});
        model_stored = 1'b0;
        exp_model    = 1'b0;
    endtask

    // Entered at the negedge of cycle T+1 of an accepted read.
    task automatic read_finish(input int npulse);
        logic       e;
        logic [1:0] exp_rsp;
        exp_rsp = 2'b00;
        for (int k = 1; k <= WIN + 4; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            dro_out = (npulse > 0) && (k >= 3) && (k < 3 + npulse);
            e = (k == 1);
            total++;
            if (dro_reset !== e) begin
                bad++;
                $display("FAIL rd_dro_reset k=%0d got=%b required=%b", k, dro_reset, e);
            end
            total++;
            if (dro_set !== 1'b0) begin
                bad++;
                $display("FAIL rd_dro_set k=%0d got=%b required=0", k, dro_set);
            end
            e = (k >= WIN + 2);
            total++;
            if (rsp_valid !== e) begin
                bad++;
                $display("FAIL rsp_valid_timing k=%0d got=%b required=%b", k, rsp_valid, e);
            end
            if (k == WIN + 2) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty got=0 entries required>=1");
                end else begin
                    exp_rsp = sb_q.pop_front();
                end
            end
            if (k >= WIN + 2) begin
                total++;
                if (rsp_data !== exp_rsp[1]) begin
                    bad++;
                    $display("FAIL rsp_data k=%0d got=%b required=%b", k, rsp_data, exp_rsp[1]);
                end
                total++;
                if (rsp_err !== exp_rsp[0]) begin
                    bad++;
                    $display("FAIL rsp_err k=%0d got=%b required=%b", k, rsp_err, exp_rsp[0]);
                end
            end
        end
        dro_out   = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rsp_after_handshake got=%b required=0", rsp_valid);
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_handshake cmd_ready got=%b required=1", cmd_ready);
        end
    endtask

    task automatic do_read(input bit suppress, input int npulse);
        bit cap;
        prep_read(suppress, cap);
        issue(1'b1);
        read_finish(cap ? npulse : 0);
    endtask

    task automatic do_write();
        logic e;
        issue(1'b0);
        model_stored = 1'b1;
        exp_model    = 1'b1;
        for (int k = 1; k <= SEP + 2; k++) begin
            if (k > 1) @(negedge clk);
            e = (k == 1);
            total++;
            if (dro_set !== e) begin
                bad++;
                $display("FAIL wr_dro_set k=%0d got=%b required=%b", k, dro_set, e);
            end
            e = (k == SEP + 2);
            total++;
            if (cmd_ready !== e) begin
                bad++;
                $display("FAIL wr_cmd_ready k=%0d got=%b required=%b", k, cmd_ready, e);
            end
            total++;
            if (dro_reset !== 1'b0) begin
                bad++;
                $display("FAIL wr_dro_reset k=%0d got=%b required=0", k, dro_reset);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [6:0] v;
        v = {cmd_ready, dro_set, dro_reset, rsp_valid, rsp_data, rsp_err, stray_err};
        total++;
        if (v !== 7'b0) begin
            bad++;
            $display("FAIL %s_outputs got=%b required=0000000", tag, v);
        end
        total++;
        if (stray_cnt !== 8'd0) begin
            bad++;
            $display("FAIL %s_stray_cnt got=%0d required=0", tag, stray_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b required=0", cmd_ready);
        end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_release got=%b required=1", cmd_ready);
        end
        model_stored = 1'b0;
        exp_model    = 1'b0;
    endtask

    task automatic test_read_empty();
        do_read(1'b0, 1);
    endtask

    task automatic test_write_read();
        do_write();
        do_read(1'b0, 1);
    endtask

    task automatic test_missing_out();
        do_write();
        do_read(1'b1, 1);
        do_read(1'b0, 1);
    endtask

    task automatic test_multi_pulse();
        do_write();
        do_read(1'b0, 3);
    endtask

    task automatic test_back_to_back();
        logic e;
        bit   cap;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_start_ready got=%b required=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        @(negedge clk);
        cmd_op       = 1'b1;
        model_stored = 1'b1;
        exp_model    = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            e = (k == 5);
            total++;
            if (cmd_ready !== e) begin
                bad++;
                $display("FAIL b2b_cmd_ready k=%0d got=%b required=%b", k, cmd_ready, e);
            end
            e = (k == 1);
            total++;
            if (dro_set !== e) begin
                bad++;
                $display("FAIL b2b_dro_set k=%0d got=%b required=%b", k, dro_set, e);
            end
            e = (k == 6);
            total++;
            if (dro_reset !== e) begin
                bad++;
                $display("FAIL b2b_dro_reset k=%0d got=%b required=%b", k, dro_reset, e);
            end
            total++;
            if (dro_set === 1'b1 && dro_reset === 1'b1) begin
                bad++;
                $display("FAIL b2b_overlap k=%0d got=11 required=not both high", k);
            end
        end
        prep_read(1'b0, cap);
        read_finish(cap ? 1 : 0);
    endtask

    task automatic test_stray();
        total++;
        if (stray_err !== 1'b0) begin
            bad++;
            $display("FAIL stray_err_initial got=%b required=0", stray_err);
        end
        for (int i = 0; i < 3; i++) begin
            dro_out = 1'b1;
            @(negedge clk);
            dro_out = 1'b0;
            @(negedge clk);
        end
        total++;
        if (stray_err !== 1'b1) begin
            bad++;
            $display("FAIL stray_err_set got=%b required=1", stray_err);
        end
        total++;
        if (stray_cnt !== CNT3) begin
            bad++;
            $display("FAIL stray_cnt got=%0d required=%0d", stray_cnt, CNT3);
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL stray_fsm_idle cmd_ready got=%b required=1", cmd_ready);
        end
        do_read(1'b0, 1);
        total++;
        if (stray_err !== 1'b1) begin
            bad++;
            $display("FAIL stray_err_sticky got=%b required=1", stray_err);
        end
        total++;
        if (stray_cnt !== CNT3) begin
            bad++;
            $display("FAIL stray_cnt_hold got=%0d required=%0d", stray_cnt, CNT3);
        end
    endtask

    task automatic test_reset_mid();
        do_write();
        issue(1'b1);
        model_stored = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_ready_before_edge got=%b required=0", cmd_ready);
        end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_ready_after_release got=%b required=1", cmd_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL dropped_rsp k=%0d got=%b required=0", k, rsp_valid);
            end
        end
        exp_model = 1'b0;
        do_read(1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_read_empty();
        test_write_read();
        test_missing_out();
        test_multi_pulse();
        test_back_to_back();
        test_stray();
        test_reset_mid();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dro_pulse_sequencer.md
DRO_PULSE_SEQUENCER -- requirements
Module: dro_pulse_sequencer

Interface
REQ-001 Parameter SEP_CYCLES, default 3: guard cycles after a dro_set pulse before any further DRO pulse; legal range 1..15.
REQ-002 Parameter WINDOW, default 4: cycles after a dro_reset pulse during which dro_out is sampled; legal range 1..15.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port cmd_valid, input, 1: command request.
REQ-006 Port cmd_op, input, 1: command type; 0 = write (set DRO), 1 = read (destructive readout).
REQ-007 Port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-008 Port dro_set, output, 1: single-cycle set pulse to the DRO.
REQ-009 Port dro_reset, output, 1: single-cycle reset/readout pulse to the DRO.
REQ-010 Port dro_out, input, 1: DRO output pulse, already synchronous to clk.
REQ-011 Port rsp_valid, output, 1: read response available.
REQ-012 Port rsp_ready, input, 1: response consumed when rsp_valid and rsp_ready are both high.
REQ-013 Port rsp_data, output, 1: bit read from the DRO.
REQ-014 Port rsp_err, output, 1: read bit differs from the expected stored bit.
REQ-015 Port stray_err, output, 1: sticky flag for a dro_out pulse outside any sample window.
REQ-016 Port stray_cnt, output, 8: saturating count of stray dro_out pulses.

Function
REQ-017 The FSM SHALL have states IDLE, SET_PULSE, GUARD, RST_PULSE, WAIT_OUT and RESP; cmd_ready SHALL be high only in IDLE.
REQ-018 A write accepted at edge T SHALL enter SET_PULSE with dro_set high for exactly cycle T+1, then GUARD for SEP_CYCLES cycles, then IDLE, so cmd_ready rises at T+2+SEP_CYCLES.
REQ-019 On a write, the internal expected bit SHALL be set to 1; a write while expected is already 1 SHALL still issue dro_set.
REQ-020 A read accepted at edge T SHALL enter RST_PULSE with dro_reset high for exactly cycle T+1, then WAIT_OUT for cycles T+2..T+1+WINDOW.
REQ-021 Any dro_out high in WAIT_OUT SHALL set the captured bit to 1; multiple pulses in one window SHALL still yield 1 with no error.
REQ-022 After WAIT_OUT the FSM SHALL enter RESP, with rsp_valid high from cycle T+2+WINDOW and rsp_data = captured bit.
REQ-023 In RESP, rsp_err SHALL equal captured XOR expected.
REQ-024 In RESP, rsp_valid, rsp_data and rsp_err SHALL stay stable until the rsp_ready handshake; the FSM SHALL then return to IDLE on the next cycle.
REQ-025 On entering RESP, the expected bit SHALL be cleared to 0, modelling destructive readout.
REQ-026 dro_set and dro_reset SHALL never be high in the same cycle, and never within SEP_CYCLES cycles after a dro_set pulse.
REQ-027 A dro_out pulse in any state other than WAIT_OUT SHALL set stray_err (sticky until reset) and SHALL NOT affect the captured bit or the FSM.
REQ-028 cmd_op SHALL be sampled only at the acceptance edge.

Reset
REQ-029 While rst_n is low, the FSM SHALL be in IDLE and the expected bit, the captured bit and all counters SHALL be 0.
REQ-030 While rst_n is low, outputs SHALL be: cmd_ready=0, dro_set=0, dro_reset=0, rsp_valid=0, rsp_data=0, rsp_err=0, stray_err=0, stray_cnt=0.
REQ-031 An assertion of rst_n mid-operation (any state) SHALL force the REQ-030 values immediately, without waiting for clk; an in-flight command SHALL be dropped with no response.
REQ-032 cmd_ready SHALL go high on the first clk edge after rst_n deasserts.

Configuration
REQ-033 With macro DRO_SEQ_STRAY_CNT_EN defined, stray_cnt SHALL increment by 1 per stray dro_out pulse and saturate at 255.
REQ-034 Without DRO_SEQ_STRAY_CNT_EN, stray_cnt SHALL be tied to 0; stray_err behaviour SHALL be unchanged.

Verification (SEP_CYCLES=3, WINDOW=4)
REQ-035 Write at edge T=0, then read; DRO model pulses dro_out 2 cycles after dro_reset -> dro_set at cycle 1, cmd_ready high at cycle 5, rsp_data=1, rsp_err=0.
REQ-036 Read after reset with no prior write and no dro_out -> rsp_valid at T+6, rsp_data=0, rsp_err=0.
REQ-037 Write, then read with the model suppressing dro_out -> rsp_data=0, rsp_err=1; an immediate second read -> rsp_data=0, rsp_err=0.
REQ-038 Read cmd_valid held high through the write's GUARD -> cmd_ready low for cycles 1..4, dro_reset no earlier than cycle 6, never overlapping dro_set.
REQ-039 dro_out pulsed 3 times in IDLE -> stray_err=1, stray_cnt=3 with the macro (0 without); a subsequent read is unaffected.
REQ-040 rst_n driven low during WAIT_OUT -> all REQ-030 values hold immediately, no rsp_valid afterwards, and cmd_ready=1 one edge after release.
